// File: rtl/reduction_packer.sv
// Serial-to-parallel lane collector feeding the adder-tree reduction.
// Elements fill lanes in order; a vector closes on the last lane or on I_Last, and unfilled lanes stay zero.
module reduction_packer #(
  parameter int WIDTH   = 8,
  parameter int NUM_MOD = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_Valid,
  input  logic [WIDTH-1:0]           I_Data,
  input  logic                       I_Last,
  output logic                       O_Ready,
  output logic                       O_Valid,
  output logic [WIDTH*NUM_MOD-1:0]   O_Data,
  output logic [$clog2(NUM_MOD):0]   O_Count,
  input  logic                       I_Ready
);

  localparam int IW = $clog2(NUM_MOD);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MOD - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [NUM_MOD-1:0][WIDTH-1:0]   lanes_q, lanes_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [CW-1:0]                   count_q, count_d;

  logic in_fire_s;
  logic out_fire_s;
  logic close_s;

  assign O_Ready    = (state_q == FILL);
  assign O_Valid    = (state_q == HOLD);
  assign O_Data     = lanes_q;
  assign O_Count    = count_q;

  assign in_fire_s  = I_Valid && (state_q == FILL);
  assign out_fire_s = I_Ready && (state_q == HOLD);
  // The last lane closes the vector even without I_Last, so idx never wraps.
  assign close_s    = (idx_q == LAST_IDX) || I_Last;

  // Next-state: lane writes while filling, clear-and-restart on output handshake.
  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    idx_d   = idx_q;
    count_d = count_q;
    case (state_q)
      FILL: begin
        if (in_fire_s) begin
          lanes_d[idx_q] = I_Data;
          if (close_s) begin
            state_d = HOLD;
            count_d = CW'(idx_q) + CW'(1);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        if (out_fire_s) begin
          state_d = FILL;
          lanes_d = '0;
          idx_d   = '0;
          count_d = '0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = FILL;
        lanes_d = '0;
        idx_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // State, lane buffer, fill index and count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      lanes_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

endmodule

// File: doc/reduction_packer.md
Name: reduction_packer

Overview:
- Serial-to-parallel collector that builds the lane vector consumed by the adder-tree reduction.
- Accepts one WIDTH-bit element per cycle over a valid/ready handshake and packs elements into NUM_MOD lanes.
- Presents the completed vector, plus an element count, on a valid/ready output.
- A vector closes when all lanes are full or when the producer marks the last element; unfilled lanes read as zero so they are neutral in the sum.

Parameters:
- WIDTH, 8, bit width of one element/lane
- NUM_MOD, 32, number of lanes; power of two, >= 2

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- I_Valid  input  1  upstream element valid
- I_Data  input  WIDTH  upstream element
- I_Last  input  1  element is the final one of the current vector; qualified by I_Valid
- O_Ready  output  1  packer can accept an element this cycle
- O_Valid  output  1  packed vector valid
- O_Data  output  WIDTH*NUM_MOD  packed vector; lane i occupies bits WIDTH*(i+1)-1 : WIDTH*i
- O_Count  output  $clog2(NUM_MOD)+1  number of filled lanes, 1..NUM_MOD while O_Valid
- I_Ready  input  1  downstream (adder tree stage) accepts the vector

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to FILL.
  - Lane buffer is all-zero; internal fill index and O_Count are 0; O_Valid=0.
  - O_Ready=1 once reset deasserts.
- Outputs and handshakes:
  - O_Ready = (state==FILL), derived combinationally from state only.
  - O_Valid = (state==HOLD).
  - O_Data and O_Count are driven directly from registers.
  - Input handshake: I_Valid && O_Ready. Output handshake: O_Valid && I_Ready.
- State FILL:
  - On each input handshake, I_Data is written into lane[idx] and idx increments.
  - Closing condition: idx==NUM_MOD-1 (last lane) or I_Last=1.
  - When the closing condition is met, at the next edge: state goes to HOLD and O_Count = idx+1.
  - Latency: the closing element is accepted at edge t; O_Valid=1 after edge t, with O_Data complete.
  - When I_Valid=0, nothing changes. I_Last without I_Valid is ignored.
- State HOLD:
  - O_Data and O_Count are held stable and no input is accepted.
  - On the output handshake, at the next edge: the buffer is cleared to zero, idx=0, O_Count=0, and state goes to FILL.
  - Result: minimum period is N+1 cycles per N-element vector.
- Width and arithmetic rules:
  - idx is $clog2(NUM_MOD) bits and never wraps. Reaching the last lane forces a close regardless of I_Last.
  - Lanes >= O_Count are guaranteed zero.
  - No arithmetic is performed on the data.
- Boundary conditions:
  - I_Last on the first element gives O_Count=1, with only lane 0 non-zero.
  - I_Last together with the last lane is a single close; O_Count=NUM_MOD.
  - I_Ready asserted while in FILL is ignored.
  - Upstream holds I_Valid, I_Data and I_Last stable while O_Ready=0; the packer does not sample them.
  - Reset asserted mid-fill or in HOLD discards the partial vector immediately; O_Valid drops asynchronously.

Test Plan:
- Full vector, no backpressure (defaults): feed 32 elements of value i+1 with I_Ready=1.
  - O_Valid rises the cycle after element 32; lane i = i+1; O_Count=32; downstream tree sum = 528.
  - O_Ready low for exactly 1 cycle.
- Early close: feed 5, 6, 7, 8, 9 with I_Last on the 5th.
  - O_Count=5; lanes 0..4 = 5..9; lanes 5..31 = 0; tree sum = 35.
- Backpressure: complete a vector, then hold I_Ready=0 for 10 cycles while upstream keeps I_Valid=1.
  - O_Valid, O_Data and O_Count stay stable; O_Ready=0 throughout; no element is lost.
  - The held element lands in lane 0 of the next vector after I_Ready=1.
- Back-to-back: two vectors streamed with I_Valid=1 continuously (8 elements with I_Last, then 32 elements of 0xFF).
  - Second vector carries no residue from the first; O_Count=8, then 32; second sum = 8160.
- Single element: one element 0xAB with I_Last.
  - O_Count=1; O_Data = 0xAB in lane 0, zero elsewhere.
- Reset mid-fill: assert reset after 12 elements.
  - O_Valid=0, O_Count=0, O_Data=0 immediately.
  - After release, the next 3 elements with I_Last give O_Count=3 with no stale lanes.
